// File: rtl/fma_dot_sequencer.sv
// Streams (a,b) pairs into a single-precision FMA with C = running accumulator; returns the dot product.
// One element per FMA_LAT+2 cycles; stalls in FETCH on in_valid low, holds the result in DONE until res_ready.
module fma_dot_sequencer #(
  parameter int WIDTH     = 32,
  parameter int LEN_WIDTH = 8,
  parameter int FMA_LAT   = 1
) (
  input  logic                 clk,
  input  logic                 RST,
  input  logic                 start,
  input  logic [LEN_WIDTH-1:0] len,
  input  logic [WIDTH-1:0]     acc_init,
  input  logic [1:0]           rnd_in,
  input  logic                 in_valid,
  output logic                 in_ready,
  input  logic [WIDTH-1:0]     in_a,
  input  logic [WIDTH-1:0]     in_b,
  output logic [WIDTH-1:0]     fma_A,
  output logic [WIDTH-1:0]     fma_B,
  output logic [WIDTH-1:0]     fma_C,
  output logic [1:0]           fma_rnd,
  output logic                 fma_enable,
  input  logic [WIDTH-1:0]     fma_result,
  output logic                 res_valid,
  input  logic                 res_ready,
  output logic [WIDTH-1:0]     res_data,
  output logic                 busy
);

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_FETCH = 3'd1,
    S_ISSUE = 3'd2,
    S_WAIT  = 3'd3,
    S_DONE  = 3'd4
  } state_t;

  localparam logic [2:0]           LAT_LOAD = 3'(FMA_LAT);
  localparam logic [LEN_WIDTH-1:0] REM_LAST = LEN_WIDTH'(1);

  state_t               r_state;
  state_t               w_state_nxt;
  logic [WIDTH-1:0]     r_acc;
  logic [LEN_WIDTH-1:0] r_rem;
  logic [2:0]           r_lat;
  logic                 w_accept;
  logic                 w_capture;
  logic                 w_len_zero;

  assign w_len_zero = (len == '0);

  always_comb begin
    w_state_nxt = r_state;
    w_accept    = 1'b0;
    w_capture   = 1'b0;
    case (r_state)
      S_IDLE: begin
        if (start) begin
          w_state_nxt = w_len_zero ? S_DONE : S_FETCH;
        end
      end
      S_FETCH: begin
        if (in_valid && in_ready) begin
          w_accept    = 1'b1;
          w_state_nxt = S_ISSUE;
        end
      end
      S_ISSUE: begin
        w_state_nxt = S_WAIT;
      end
      S_WAIT: begin
        // The counter hits zero exactly FMA_LAT cycles after ISSUE, the only cycle the result is valid.
        if (r_lat == 3'd0) begin
          w_capture   = 1'b1;
          w_state_nxt = (r_rem == REM_LAST) ? S_DONE : S_FETCH;
        end
      end
      S_DONE: begin
        if (res_valid && res_ready) begin
          w_state_nxt = S_IDLE;
        end
      end
      default: begin
        w_state_nxt = S_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (!RST) begin
      r_state    <= S_IDLE;
      r_acc      <= '0;
      r_rem      <= '0;
      r_lat      <= '0;
      in_ready   <= 1'b0;
      fma_enable <= 1'b0;
      res_valid  <= 1'b0;
      busy       <= 1'b0;
      fma_A      <= '0;
      fma_B      <= '0;
      fma_C      <= '0;
      fma_rnd    <= '0;
      res_data   <= '0;
    end else begin
      r_state    <= w_state_nxt;
      in_ready   <= (w_state_nxt == S_FETCH);
      fma_enable <= (w_state_nxt == S_ISSUE);
      res_valid  <= (w_state_nxt == S_DONE);
      busy       <= (w_state_nxt != S_IDLE);

      case (r_state)
        S_IDLE: begin
          if (start) begin
            r_rem   <= len;
            r_acc   <= acc_init;
            fma_rnd <= rnd_in;
            if (w_len_zero) begin
              res_data <= acc_init;
            end
          end
        end
        S_FETCH: begin
          if (w_accept) begin
            fma_A <= in_a;
            fma_B <= in_b;
            fma_C <= r_acc;
            r_lat <= LAT_LOAD;
          end
        end
        S_ISSUE: begin
          r_lat <= r_lat - 3'd1;
        end
        S_WAIT: begin
          if (r_lat != 3'd0) begin
            r_lat <= r_lat - 3'd1;
          end
          if (w_capture) begin
            r_acc <= fma_result;
            r_rem <= r_rem - REM_LAST;
            if (r_rem == REM_LAST) begin
              res_data <= fma_result;
            end
          end
        end
        default: begin
        end
      endcase
    end
  end

endmodule
